// File: rtl/result_uart_tx.sv
// result_uart_tx
// Reads an H x V 8-bit image out of the result frame RAM in raster order
// (address 0 upward). Each pixel is sent as one UART 8N1 character so the
// finished frame can be dumped to a host.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset (aborts a dump in progress)
//   start  - frame-dump request, only looked at while idle
//   doutb  - result RAM read data (synchronous RAM, 1-cycle latency)
//   addrb  - result RAM read address (registered)
//   enb    - result RAM read enable (registered, one cycle per pixel)
//   txd    - UART serial output, idles high
//   busy   - dump in progress
//   done   - frame complete, held until the next start is accepted
//
// Per-pixel timing is 2 fetch cycles (REQ, WAIT) followed by 10 bit times.
// txd stays high during the two fetch cycles.
module result_uart_tx #(
  parameter int H            = 500,
  parameter int V            = 500,
  parameter int AW           = 18,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    doutb,
  output logic [AW-1:0] addrb,
  output logic          enb,
  output logic          txd,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_START, S_DATA, S_STOP
  } state_t;

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] PIX_LAST  = AW'(H * V - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] addrb_d;
  logic          enb_d, txd_d, busy_d, done_d;
  logic          baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    shift_d = shift_q;
    addrb_d = addrb;
    enb_d   = enb;
    txd_d   = txd;
    busy_d  = busy;
    done_d  = done;

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        enb_d = 1'b0;
        if (start) begin
          idx_d   = '0;
          addrb_d = '0;
          enb_d   = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = S_REQ;
        end
      end

      // RAM samples addrb/enb at the edge that ends this cycle.
      S_REQ: begin
        enb_d   = 1'b0;
        state_d = S_WAIT;
      end

      // Read data is valid only in this cycle; capture it now, since the
      // RAM output is not guaranteed to hold afterwards.
      S_WAIT: begin
        shift_d = doutb;
        txd_d   = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end

      S_START: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d  = '0;
          txd_d   = shift_q[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end

      // txd already shows shift_q[0]; on each bit boundary shift right and
      // present the next bit (shift_q[1]) in the same edge.
      S_DATA: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
            bit_d   = bit_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        baud_d = baud_q + 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (idx_q == PIX_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            addrb_d = idx_q + 1'b1;
            enb_d   = 1'b1;
            state_d = S_REQ;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      shift_q <= '0;
      addrb   <= '0;
      enb     <= 1'b0;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      shift_q <= shift_d;
      addrb   <= addrb_d;
      enb     <= enb_d;
      txd     <= txd_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Testbench for result_uart_tx with H=4, V=2, CLKS_PER_BIT=4.
// Outputs are logged every negedge, indexed by edge number relative to the
// edge that accepts start (E0). A generic UART decoder then scans the txd log.
module tb_result_uart_tx;

  localparam int H   = 4;
  localparam int V   = 2;
  localparam int AW  = 4;
  localparam int C   = 4;
  localparam int PER = 2 + 10 * C;
  localparam int LOG = 400;
  localparam int NPX = H * V;
  localparam int DONE_T = NPX * PER;   // 336

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    doutb;
  logic [AW-1:0] addrb;
  logic          enb, txd, busy, done;

  result_uart_tx #(.H(H), .V(V), .AW(AW), .CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .doutb (doutb),
    .addrb (addrb),
    .enb   (enb),
    .txd   (txd),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model. When not enabled the output is scrambled, so a
  // design that reads doutb outside the WAIT cycle sends garbage.
  logic [7:0] mem [0:15];
  logic [7:0] exp_px [0:7];

  always @(posedge clk) begin
    if (enb) doutb <= mem[addrb];
    else     doutb <= 8'($urandom);
  end

  int cyc = 0;
  int e0  = 1 << 30;
  always @(posedge clk) cyc <= cyc + 1;

  logic          t_log [LOG];
  logic          b_log [LOG];
  logic          d_log [LOG];
  logic          e_log [LOG];
  logic [AW-1:0] a_log [LOG];

  always @(negedge clk) begin
    if (cyc >= e0 && cyc - e0 < LOG) begin
      t_log[cyc-e0] <= txd;
      b_log[cyc-e0] <= busy;
      d_log[cyc-e0] <= done;
      e_log[cyc-e0] <= enb;
      a_log[cyc-e0] <= addrb;
    end
  end

  int nvec = 0;
  int nmis = 0;

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected output snapshots of a single frame, hand-derived.
  typedef struct {
    int         t;
    logic       txd;
    logic       busy;
    logic       done;
    logic       enb;
    logic [3:0] addrb;
  } vec_t;

  vec_t vt [14];

  task automatic fill_table();
    vt[0]  = '{0,   1'b1, 1'b1, 1'b0, 1'b1, 4'd0};  // REQ pixel 0
    vt[1]  = '{1,   1'b1, 1'b1, 1'b0, 1'b0, 4'd0};  // WAIT
    vt[2]  = '{2,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0};  // start bit begins
    vt[3]  = '{5,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0};  // last start-bit cycle
    vt[4]  = '{6,   1'b0, 1'b1, 1'b0, 1'b0, 4'd0};  // 0x00 bit0
    vt[5]  = '{42,  1'b1, 1'b1, 1'b0, 1'b1, 4'd1};  // REQ pixel 1
    vt[6]  = '{43,  1'b1, 1'b1, 1'b0, 1'b0, 4'd1};  // WAIT pixel 1
    vt[7]  = '{48,  1'b1, 1'b1, 1'b0, 1'b0, 4'd1};  // 0x01 bit0
    vt[8]  = '{94,  1'b0, 1'b1, 1'b0, 1'b0, 4'd2};  // 0xA5 bit1
    vt[9]  = '{308, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7};  // 0x3C bit2
    vt[10] = '{328, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7};  // 0x3C bit7
    vt[11] = '{335, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7};  // final stop bit
    vt[12] = '{336, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7};  // done
    vt[13] = '{340, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7};  // done held
  endtask

  task automatic clear_log();
    for (int i = 0; i < LOG; i++) begin
      t_log[i] = 1'bx; b_log[i] = 1'bx; d_log[i] = 1'bx;
      e_log[i] = 1'bx; a_log[i] = 'x;
    end
  endtask

  // Called at a negedge; the following posedge is E0.
  task automatic pulse_start();
    clear_log();
    e0 = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int n);
    while (cyc < e0 + n) @(negedge clk);
  endtask

  logic [7:0] dec_val [16];
  int         dec_t   [16];
  logic       dec_ok  [16];
  int         ndec;

  // Generic 8N1 decoder: find falling edges, sample mid-bit.
  task automatic decode(input int upto);
    int i;
    ndec = 0;
    i = 1;
    while (i + 10 * C < upto && ndec < 16) begin
      if (t_log[i-1] === 1'b1 && t_log[i] === 1'b0) begin
        logic [7:0] v;
        for (int j = 0; j < 8; j++) v[j] = t_log[i + C * (1 + j) + C / 2];
        dec_val[ndec] = v;
        dec_t[ndec]   = i;
        dec_ok[ndec]  = (t_log[i + C / 2] === 1'b0) && (t_log[i + 9 * C + C / 2] === 1'b1);
        ndec++;
        i = i + 9 * C + C / 2;
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_frame(input string tag, input int upto);
    int n;
    decode(upto);
    check({tag, " byte_count"}, ndec, NPX);
    for (int k = 0; k < NPX && k < ndec; k++) begin
      check($sformatf("%s byte%0d value", tag, k), dec_val[k], exp_px[k]);
      check($sformatf("%s byte%0d fall_edge", tag, k), dec_t[k], 2 + PER * k);
      check($sformatf("%s byte%0d framing", tag, k), dec_ok[k], 1);
    end
    n = 0;
    for (int i = 0; i < upto; i++) begin
      if (e_log[i] === 1'b1) begin
        check($sformatf("%s enb%0d edge", tag, n), i, PER * n);
        check($sformatf("%s enb%0d addrb", tag, n), a_log[i], n);
        n++;
      end
    end
    check({tag, " enb_pulses"}, n, NPX);
    check({tag, " busy_before_done"}, b_log[DONE_T-1], 1);
    check({tag, " done_before"}, d_log[DONE_T-1], 0);
    check({tag, " busy_fall"}, b_log[DONE_T], 0);
    check({tag, " done_rise"}, d_log[DONE_T], 1);
  endtask

  initial begin
    exp_px = '{8'h00, 8'h01, 8'hA5, 8'hFF, 8'h80, 8'h7E, 8'h55, 8'h3C};
    for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? exp_px[i] : 8'h00;
    fill_table();

    // Reset state, with start pulsed while reset is held.
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("reset txd", txd, 1);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset enb", enb, 0);
    check("reset addrb", addrb, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset busy", busy, 0);
    check("post_reset txd", txd, 1);

    // Single frame: table-driven snapshots plus decoded frame.
    pulse_start();
    wait_until(345);
    for (int v = 0; v < 14; v++) begin
      check($sformatf("vec t=%0d txd", vt[v].t), t_log[vt[v].t], vt[v].txd);
      check($sformatf("vec t=%0d busy", vt[v].t), b_log[vt[v].t], vt[v].busy);
      check($sformatf("vec t=%0d done", vt[v].t), d_log[vt[v].t], vt[v].done);
      check($sformatf("vec t=%0d enb", vt[v].t), e_log[vt[v].t], vt[v].enb);
      check($sformatf("vec t=%0d addrb", vt[v].t), a_log[vt[v].t], vt[v].addrb);
    end
    check_frame("single", DONE_T + 1);

    // Start pulsed mid-frame at E100 must be ignored.
    repeat (3) @(negedge clk);
    pulse_start();
    check("restart done_cleared", d_log[0], 0);
    wait_until(99);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(345);
    check_frame("ignored_start", DONE_T + 1);

    // Asynchronous abort mid-DATA at E150.
    repeat (3) @(negedge clk);
    pulse_start();
    wait_until(150);
    check("abort pre busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort txd", txd, 1);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort enb", enb, 0);
    check("abort addrb", addrb, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort idle txd", txd, 1);
    check("abort idle busy", busy, 0);
    pulse_start();
    wait_until(345);
    check_frame("after_abort", DONE_T + 1);

    // start held high: next frame accepted one cycle after done.
    repeat (3) @(negedge clk);
    clear_log();
    e0 = cyc + 1;
    start = 1'b1;
    wait_until(345);
    start = 1'b0;
    check_frame("continuous", DONE_T + 1);
    check("cont enb_at_336", e_log[DONE_T], 0);
    check("cont enb_at_337", e_log[DONE_T+1], 1);
    check("cont addrb_at_337", a_log[DONE_T+1], 0);
    check("cont done_at_337", d_log[DONE_T+1], 0);
    check("cont busy_at_337", b_log[DONE_T+1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Reads a processed H×V 8-bit image out of the result frame RAM, one pixel at a time in raster order (address 0 upward).
- Serialises each pixel over a UART 8N1 line so the edge-detected frame can be dumped to a host.
- This block is the read side of the result RAM. The edge-detection engine writes that RAM.
- A frame dump starts on the `start` pulse, which is driven from the engine's completion flag. The block reports `busy` during the dump and `done` when it finishes.

Parameters:
- H, 500, image width in pixels.
- V, 500, image height in pixels.
- AW, 18, RAM address width. H*V must be ≤ 2^AW.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame-dump request; sampled only in IDLE.
- doutb  in  8  result RAM read data; synchronous RAM, 1-cycle read latency.
- addrb  out  AW  result RAM read address (registered).
- enb  out  1  result RAM read enable (registered).
- txd  out  1  UART serial output; idles high.
- busy  out  1  high from start acceptance until the last stop bit ends.
- done  out  1  high after a complete frame; held until the next start is accepted.

Behaviour:
- Reset (rst_n low, asynchronous) gives:
  - state IDLE, addrb=0, enb=0, txd=1, busy=0, done=0.
  - Pixel index, bit counter, baud counter and shift register all cleared.
- Reset mid-frame aborts the dump immediately. txd goes high asynchronously. No partial-frame resume.
- States: IDLE, REQ, WAIT, START, DATA, STOP.
- IDLE:
  - txd=1, enb=0.
  - On an edge with start=1: addrb<=0, enb<=1, busy<=1, done<=0, go to REQ.
  - start in any other state is ignored.
- REQ (1 cycle):
  - The RAM samples addrb/enb at the edge ending this state.
  - enb<=0, go to WAIT.
- WAIT (1 cycle):
  - doutb is valid during this cycle.
  - At the edge ending WAIT: shift register<=doutb, txd<=0, baud counter<=0, go to START.
- START:
  - txd=0 for exactly CLKS_PER_BIT cycles.
  - Then txd<=shift[0], bit counter<=0, go to DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles, LSB first.
  - After each bit, shift right and increment the bit counter.
  - After bit 7: txd<=1, go to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. Then:
  - If pixel index == H*V-1: busy<=0, done<=1, go to IDLE.
  - Otherwise: index<=index+1, addrb<=index+1, enb<=1, go to REQ.
- Timing:
  - Per-pixel period is exactly 2 + 10*CLKS_PER_BIT cycles.
  - There is no idle gap between bytes beyond the 2 fetch cycles, during which txd stays high.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. Width is $clog2(CLKS_PER_BIT).
- Pixel index wraps only via return to IDLE; it never exceeds H*V-1.
- start=1 in the same cycle that done would assert: start is not sampled that cycle (state is STOP). The next edge in IDLE accepts it.
- start held high continuously: frames repeat back-to-back, with one IDLE cycle between them.
- enb is high only in REQ. The RAM is never read outside the fetch window.

Test Plan (H=4, V=2, CLKS_PER_BIT=4, unless noted; E0 = edge on which start is sampled):
- Reset check: rst_n=0 → txd=1, busy=0, done=0, enb=0, addrb=0. Pulse start while rst_n=0 → no activity.
- Single frame: RAM holds 0x00,0x01,0xA5,0xFF,0x80,0x7E,0x55,0x3C; pulse start 1 cycle.
  - A UART monitor decodes exactly those 8 bytes in order.
  - The txd falling edge of byte k occurs at E2+42k.
  - busy falls and done rises at E336.
- RAM access: enb is high for exactly 1 cycle per pixel, with addrb = 0,1,…,7 in sequence.
  - doutb is changed after the WAIT-state capture; the transmitted byte must be unaffected.
- Ignored start: pulse start at E100 (mid-frame) → no restart, output identical to single frame, done at E336.
- Async abort: drop rst_n at E150 mid-DATA → txd=1 immediately, all outputs at reset values.
  - After release, a new start produces a full frame beginning at pixel 0.
- Continuous start: hold start=1 → second frame's addrb=0 fetch begins at E337. done deasserts on that acceptance.
